// File: rtl/rv32_alu_arbiter_pkg.sv
// Shared types for the ALU arbiter slice: machine word, ALU operation encoding
// and the request bundle handed to the integer ALU.
package rv32_alu_arbiter_pkg;

   typedef logic [31:0] rv32_word;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_opsel_t;

   localparam logic [3:0] ALU_OPSEL_LAST = 4'd9;

   typedef struct packed {
      rv32_word   op1;
      rv32_word   op2;
      alu_opsel_t opsel;
   } alu_req_t;

   // Encodings above ALU_AND are reserved and produce a zero result.
   function automatic logic alu_opsel_illegal(input logic [3:0] opsel);
      return opsel > ALU_OPSEL_LAST;
   endfunction

endpackage

// File: rtl/rv32_alu_arbiter_alu.sv
// Combinational RV32 integer ALU. Shift amounts use the whole of op2, so a
// shift by 32 or more flushes the word (or sign-fills for SRA).
module rv32_int_alu
   import rv32_alu_arbiter_pkg::*;
(
   input  alu_req_t req,
   output rv32_word result,
   output logic     illegal
);

   always_comb begin
      result  = '0;
      illegal = alu_opsel_illegal(req.opsel);
      case (req.opsel)
         ALU_ADD:  result = req.op1 + req.op2;
         ALU_SUB:  result = req.op1 - req.op2;
         ALU_SLL:  result = req.op1 << req.op2;
         ALU_SLT:  result = {31'd0, $signed(req.op1) < $signed(req.op2)};
         ALU_SLTU: result = {31'd0, req.op1 < req.op2};
         ALU_XOR:  result = req.op1 ^ req.op2;
         ALU_SRL:  result = req.op1 >> req.op2;
         ALU_SRA:  result = rv32_word'($signed(req.op1) >>> req.op2);
         ALU_OR:   result = req.op1 | req.op2;
         ALU_AND:  result = req.op1 & req.op2;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/rv32_alu_arbiter_rr.sv
// Combinational round-robin picker: first eligible requester at or after ptr,
// where eligible = req & mask. Returns one-hot grant plus its index.
module rv32_rr_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic [NUM_REQ-1:0] mask,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               grant_any
);

   logic [NUM_REQ-1:0] eligible;
   int                 idx;

   assign eligible = req & mask;

   // Walk offsets from farthest to nearest so the nearest eligible one wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (eligible[idx]) begin
            grant_any = 1'b1;
            grant_idx = ID_W'(idx);
         end
      end
      if (grant_any) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/rv32_alu_arbiter.sv
// Shares one rv32_int_alu between NUM_REQ requesters with round-robin arbitration,
// optional grant lock and a single registered, backpressurable result stage.
module rv32_alu_arbiter
   import rv32_alu_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   parameter  int TAG_W   = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ-1:0][31:0]        req_op1,
   input  logic [NUM_REQ-1:0][31:0]        req_op2,
   input  logic [NUM_REQ-1:0][3:0]         req_opsel,
   input  logic [NUM_REQ-1:0]              req_lock,
   input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [31:0]                     rsp_result,
   output logic [ID_W-1:0]                 rsp_id,
   output logic [TAG_W-1:0]                rsp_tag,
   output logic                            rsp_illegal
);

   logic             rsp_valid_reg,   rsp_valid_next;
   rv32_word         rsp_result_reg,  rsp_result_next;
   logic [ID_W-1:0]  rsp_id_reg,      rsp_id_next;
   logic [TAG_W-1:0] rsp_tag_reg,     rsp_tag_next;
   logic             rsp_illegal_reg, rsp_illegal_next;
   logic [ID_W-1:0]  rr_ptr_reg,      rr_ptr_next;
   logic             lock_active_reg, lock_active_next;
   logic [ID_W-1:0]  lock_owner_reg,  lock_owner_next;

   alu_req_t           alu_reqs [NUM_REQ];
   alu_req_t           sel_req;
   logic [TAG_W-1:0]   sel_tag;
   logic               sel_lock;
   logic [NUM_REQ-1:0] lock_mask;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic               grant_any;
   logic               can_accept;
   logic               transfer;
   rv32_word           alu_result;
   logic               alu_illegal;

   // While locked, only the owner may be granted.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign alu_reqs[gi]  = {req_op1[gi], req_op2[gi], req_opsel[gi]};
         assign lock_mask[gi] = !lock_active_reg || (lock_owner_reg == ID_W'(gi));
      end
   endgenerate

   rv32_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req       (req_valid),
      .ptr       (rr_ptr_reg),
      .mask      (lock_mask),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign can_accept = !rsp_valid_reg || rsp_ready;
   assign transfer   = resetn && can_accept && grant_any;
   assign req_ready  = (resetn && can_accept) ? grant : '0;

   assign sel_req  = alu_reqs[grant_idx];
   assign sel_tag  = req_tag[grant_idx];
   assign sel_lock = req_lock[grant_idx];

   rv32_int_alu u_alu (
      .req     (sel_req),
      .result  (alu_result),
      .illegal (alu_illegal)
   );

   always_comb begin
      rsp_valid_next   = rsp_valid_reg;
      rsp_result_next  = rsp_result_reg;
      rsp_id_next      = rsp_id_reg;
      rsp_tag_next     = rsp_tag_reg;
      rsp_illegal_next = rsp_illegal_reg;
      rr_ptr_next      = rr_ptr_reg;
      lock_active_next = lock_active_reg;
      lock_owner_next  = lock_owner_reg;

      if (transfer) begin
         rsp_valid_next   = 1'b1;
         rsp_result_next  = alu_result;
         rsp_id_next      = grant_idx;
         rsp_tag_next     = sel_tag;
         rsp_illegal_next = alu_illegal;
         if (sel_lock) begin
            lock_active_next = 1'b1;
            lock_owner_next  = grant_idx;
         end else begin
            // An unlocked transfer also releases any lock held by this requester.
            lock_active_next = 1'b0;
            rr_ptr_next      = (int'(grant_idx) == NUM_REQ - 1) ? '0
                                                                : ID_W'(int'(grant_idx) + 1);
         end
      end else if (rsp_ready) begin
         rsp_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rsp_valid_reg   <= 1'b0;
         rsp_result_reg  <= '0;
         rsp_id_reg      <= '0;
         rsp_tag_reg     <= '0;
         rsp_illegal_reg <= 1'b0;
         rr_ptr_reg      <= '0;
         lock_active_reg <= 1'b0;
         lock_owner_reg  <= '0;
      end else begin
         rsp_valid_reg   <= rsp_valid_next;
         rsp_result_reg  <= rsp_result_next;
         rsp_id_reg      <= rsp_id_next;
         rsp_tag_reg     <= rsp_tag_next;
         rsp_illegal_reg <= rsp_illegal_next;
         rr_ptr_reg      <= rr_ptr_next;
         lock_active_reg <= lock_active_next;
         lock_owner_reg  <= lock_owner_next;
      end
   end

   assign rsp_valid   = rsp_valid_reg;
   assign rsp_result  = rsp_result_reg;
   assign rsp_id      = rsp_id_reg;
   assign rsp_tag     = rsp_tag_reg;
   assign rsp_illegal = rsp_illegal_reg;

endmodule

// File: tb/tb_rv32_alu_arbiter.sv
// Bench for rv32_alu_arbiter: directed scenarios then random traffic, all checked
// every cycle against a transaction-level model of arbitration, lock and ALU.
module tb_rv32_alu_arbiter;

   localparam int N  = 2;
   localparam int TW = 4;
   localparam int IW = 1;

   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SRA = 4'd7;

   logic                    clk = 1'b0;
   logic                    resetn = 1'b0;
   logic [N-1:0]            req_valid;
   logic [N-1:0]            req_ready;
   logic [N-1:0][31:0]      req_op1;
   logic [N-1:0][31:0]      req_op2;
   logic [N-1:0][3:0]       req_opsel;
   logic [N-1:0]            req_lock;
   logic [N-1:0][TW-1:0]    req_tag;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [31:0]             rsp_result;
   logic [IW-1:0]           rsp_id;
   logic [TW-1:0]           rsp_tag;
   logic                    rsp_illegal;

   int n_vec = 0;
   int n_err = 0;

   // model state
   logic        m_valid;
   logic [31:0] m_result;
   int          m_id;
   logic [3:0]  m_tag;
   logic        m_ill;
   int          m_ptr;
   logic        m_lock;
   int          m_owner;

   always #5 clk = ~clk;

   rv32_alu_arbiter #(
      .NUM_REQ (N),
      .TAG_W   (TW)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op1     (req_op1),
      .req_op2     (req_op2),
      .req_opsel   (req_opsel),
      .req_lock    (req_lock),
      .req_tag     (req_tag),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_id      (rsp_id),
      .rsp_tag     (rsp_tag),
      .rsp_illegal (rsp_illegal)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return (b >= 32) ? 32'd0 : (a << b[4:0]);
         4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd4: return (a < b) ? 32'd1 : 32'd0;
         4'd5: return a ^ b;
         4'd6: return (b >= 32) ? 32'd0 : (a >> b[4:0]);
         4'd7: begin
            if (b >= 32) return a[31] ? 32'hFFFF_FFFF : 32'd0;
            return a[31] ? ~((~a) >> b[4:0]) : (a >> b[4:0]);
         end
         4'd8: return a | b;
         4'd9: return a & b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int pick();
      if (m_lock) return req_valid[m_owner] ? m_owner : -1;
      for (int k = 0; k < N; k++) begin
         int i = (m_ptr + k) % N;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_valid = 1'b0; m_result = '0; m_id = 0; m_tag = '0; m_ill = 1'b0;
      m_ptr = 0; m_lock = 1'b0; m_owner = 0;
   endtask

   task automatic set_req(input int i, input logic v, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic lk, input logic [3:0] tg);
      req_valid[i] = v; req_opsel[i] = op; req_op1[i] = a; req_op2[i] = b;
      req_lock[i] = lk; req_tag[i] = tg;
   endtask

   task automatic new_req(input int i);
      req_valid[i] = ($urandom_range(0, 3) != 0);
      req_op1[i]   = $urandom;
      req_op2[i]   = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 40));
      req_opsel[i] = 4'($urandom_range(0, 11));
      req_lock[i]  = ($urandom_range(0, 3) == 0);
      req_tag[i]   = 4'($urandom);
   endtask

   // One clock: check outputs mid-cycle, advance model, return granted index (-1 if none).
   task automatic step(output int xfer);
      logic [N-1:0] exp_ready;
      logic         can;
      int           g;
      @(negedge clk);
      can = !m_valid || rsp_ready;
      g   = pick();
      exp_ready = '0;
      if (can && g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      if (m_valid) begin
         chk("rsp_result",  64'(rsp_result),  64'(m_result));
         chk("rsp_id",      64'(rsp_id),      64'(m_id));
         chk("rsp_tag",     64'(rsp_tag),     64'(m_tag));
         chk("rsp_illegal", 64'(rsp_illegal), 64'(m_ill));
      end
      xfer = -1;
      if (can && g >= 0) begin
         xfer     = g;
         m_valid  = 1'b1;
         m_result = alu_ref(req_opsel[g], req_op1[g], req_op2[g]);
         m_id     = g;
         m_tag    = req_tag[g];
         m_ill    = (req_opsel[g] > 4'd9);
         if (req_lock[g]) begin
            m_lock = 1'b1; m_owner = g;
         end else begin
            m_lock = 1'b0; m_ptr = (g + 1) % N;
         end
         $display("xfer t=%0t req%0d op=%0d a=%h b=%h lock=%0b -> %h", $time, g,
                  req_opsel[g], req_op1[g], req_op2[g], req_lock[g], m_result);
      end else if (rsp_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int x;
      int exp_g;
      logic [31:0] held;

      m_reset();
      rsp_ready = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, OP_ADD, 32'd1, 32'd2, 1'b0, 4'd0);

      // reset state
      #12;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_result", 64'(rsp_result), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
      chk("rst_rsp_illegal", 64'(rsp_illegal), 64'd0);
      req_valid = '0;
      #1 resetn = 1'b1;
      @(posedge clk);
      #1;

      // single request
      set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7, 1'b0, 4'd3);
      rsp_ready = 1'b1;
      step(x);
      chk("single_grant", 64'(x), 64'd0);
      chk("single_valid", 64'(rsp_valid), 64'd1);
      chk("single_result", 64'(rsp_result), 64'd12);
      chk("single_id", 64'(rsp_id), 64'd0);
      chk("single_tag", 64'(rsp_tag), 64'd3);
      req_valid = '0;
      step(x);

      // both valid every cycle: alternating grants, no bubbles (pointer now at 1)
      for (int i = 0; i < N; i++) begin new_req(i); req_valid[i] = 1'b1; req_lock[i] = 1'b0; end
      exp_g = 1;
      for (int c = 0; c < 6; c++) begin
         step(x);
         chk("alt_grant", 64'(x), 64'(exp_g));
         chk("no_bubble", 64'(rsp_valid), 64'd1);
         exp_g = 1 - exp_g;
         if (x >= 0) begin new_req(x); req_valid[x] = 1'b1; req_lock[x] = 1'b0; end
      end

      // backpressure: everything held, then drain and reload in one cycle
      rsp_ready = 1'b0;
      held = rsp_result;
      for (int c = 0; c < 3; c++) begin
         step(x);
         chk("bp_held", 64'(rsp_result), 64'(held));
      end
      rsp_ready = 1'b1;
      step(x);
      chk("bp_xfer", 64'(x >= 0), 64'd1);
      chk("bp_reload", 64'(rsp_valid), 64'd1);

      // lock: req1 holds the grant for two ops while req0 waits
      req_valid = '0;
      step(x);
      set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1, 1'b0, 4'd1);
      step(x);
      set_req(0, 1'b1, OP_ADD, 32'd100, 32'd23, 1'b0, 4'd2);
      set_req(1, 1'b1, OP_SUB, 32'd50, 32'd8, 1'b1, 4'd9);
      step(x);
      chk("lock_first", 64'(x), 64'd1);
      set_req(1, 1'b1, OP_SLL, 32'd3, 32'd4, 1'b0, 4'd10);
      step(x);
      chk("lock_second", 64'(x), 64'd1);
      chk("lock_sll", 64'(rsp_result), 64'd48);
      req_valid[1] = 1'b0;
      step(x);
      chk("lock_then_0", 64'(x), 64'd0);
      req_valid = '0;
      step(x);

      // illegal opsel and arithmetic right shift
      set_req(0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'd1, 1'b0, 4'd5);
      step(x);
      chk("illegal_result", 64'(rsp_result), 64'd0);
      chk("illegal_flag", 64'(rsp_illegal), 64'd1);
      set_req(0, 1'b1, OP_SRA, 32'h8000_0000, 32'd4, 1'b0, 4'd6);
      step(x);
      chk("sra_result", 64'(rsp_result), 64'hF800_0000);
      chk("sra_flag", 64'(rsp_illegal), 64'd0);
      req_valid = '0;
      step(x);

      // async reset while a result is pending and a lock is held
      rsp_ready = 1'b0;
      set_req(0, 1'b1, OP_ADD, 32'd2, 32'd2, 1'b0, 4'd7);
      set_req(1, 1'b1, OP_ADD, 32'd9, 32'd9, 1'b1, 4'd8);
      step(x);
      chk("pre_rst_grant", 64'(x), 64'd1);
      #2 resetn = 1'b0;
      #1;
      chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("arst_rsp_result", 64'(rsp_result), 64'd0);
      chk("arst_req_ready", 64'(req_ready), 64'd0);
      m_reset();
      req_valid = '0;
      #2 resetn = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      req_valid = '1;
      step(x);
      chk("post_rst_grant", 64'(x), 64'd0);

      // random traffic
      for (int i = 0; i < N; i++) new_req(i);
      for (int c = 0; c < 400; c++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         step(x);
         for (int i = 0; i < N; i++) begin
            if (i == x || !req_valid[i]) new_req(i);
         end
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      step(x);
      step(x);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
